// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command-queue controller:
// engine state encoding and command-word width helpers.
package spi_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_POP   = 3'd1;
   localparam state_t ST_SETUP = 3'd2;
   localparam state_t ST_SHIFT = 3'd3;
   localparam state_t ST_HOLD  = 3'd4;
   localparam state_t ST_GAP   = 3'd5;

   function automatic int cs_width(input int num_cs);
      return (num_cs > 1) ? $clog2(num_cs) : 1;
   endfunction

   function automatic int cmd_width(
      input int addr_bits,
      input int data_bits,
      input int num_cs
   );
      return cs_width(num_cs) + addr_bits + data_bits;
   endfunction

endpackage

// File: rtl/spi_queue_cntrl_if.sv
// Bus bundle of spi_queue_cntrl: control, command write port,
// FIFO status and serial pins. master = host side, slave = DUT.
interface spi_queue_cntrl_if
   import spi_pkg::*;
#(
   parameter int ADDR_BITS  = 8,
   parameter int DATA_BITS  = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_CS     = 4
);
   localparam int CMD_W = cmd_width(ADDR_BITS, DATA_BITS, NUM_CS);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              start;
   logic              abort;
   logic [7:0]        clk_ratio;
   logic              cpol;
   logic              cmd_wren;
   logic [CMD_W-1:0]  cmd_in;
   logic              busy;
   logic              done;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  fifo_level;
   logic              overflow;
   logic [NUM_CS-1:0] SEN;
   logic              SCLK;
   logic              SDATA;

   modport master (
      output start, abort, clk_ratio, cpol,
      output cmd_wren, cmd_in,
      input  busy, done,
      input  fifo_full, fifo_empty,
      input  fifo_level, overflow,
      input  SEN, SCLK, SDATA
   );

   modport slave (
      input  start, abort, clk_ratio, cpol,
      input  cmd_wren, cmd_in,
      output busy, done,
      output fifo_full, fifo_empty,
      output fifo_level, overflow,
      output SEN, SCLK, SDATA
   );

endinterface

// File: rtl/spi_cmd_fifo.sv
// Command FIFO: WIDTH x DEPTH, show-ahead head, occupancy level,
// sticky overflow. Ports: wr_en/wr_data, rd_en/rd_data,
// full, empty, level, overflow.
module spi_cmd_fifo #(
   parameter  int WIDTH = 26,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level,
   output logic             overflow
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_data = mem[rd_ptr];
   assign do_rd   = rd_en && !empty;
   // a pop in the same cycle frees the slot a full write needs
   assign do_wr   = wr_en && (!full || do_rd);

   always_ff @(posedge clock) begin
      if (do_wr)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_rd)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
         if (wr_en && !do_wr)
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/spi_queue_cntrl.sv
// Queued SPI master: drains {cs_sel,address,data} commands from a
// FIFO and shifts each out MSB-first on SCLK/SDATA with SEN select.
// Ports: clock, reset_n (async, active-low), bus (slave modport).
module spi_queue_cntrl
   import spi_pkg::*;
#(
   parameter int ADDR_BITS  = 8,
   parameter int DATA_BITS  = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int NUM_CS     = 4
) (
   input logic               clock,
   input logic               reset_n,
   spi_queue_cntrl_if.slave  bus
);

   localparam int CS_W    = cs_width(NUM_CS);
   localparam int FRAME_W = ADDR_BITS + DATA_BITS;
   localparam int CMD_W   = cmd_width(ADDR_BITS, DATA_BITS, NUM_CS);
   localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int HP_W    = $clog2(2 * FRAME_W);
   localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * FRAME_W - 1);

   state_t            state;
   logic [7:0]        cnt;
   logic [HP_W-1:0]   hp;
   logic [FRAME_W-1:0] sreg;
   logic [7:0]        ratio_lat;
   logic              cpol_lat;
   logic [NUM_CS-1:0] sen;
   logic              sclk;

   logic              pop;
   logic              half_end;
   logic [CMD_W-1:0]  head;
   logic [CS_W-1:0]   head_cs;
   logic [NUM_CS-1:0] head_sen;
   logic              fifo_full;
   logic              fifo_empty;
   logic [LVL_W-1:0]  fifo_level;
   logic              overflow;

   spi_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset_n  (reset_n),
      .wr_en    (bus.cmd_wren),
      .wr_data  (bus.cmd_in),
      .rd_en    (pop),
      .rd_data  (head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_level),
      .overflow (overflow)
   );

   assign pop      = (state == ST_POP);
   assign half_end = (cnt == ratio_lat - 8'd1);
   assign head_cs  = head[CMD_W-1 -: CS_W];

   // out-of-range selects leave every SEN high
   always_comb begin
      head_sen = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (int'(head_cs) == i)
            head_sen[i] = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hp        <= '0;
         sreg      <= '0;
         ratio_lat <= 8'd1;
         cpol_lat  <= 1'b0;
         sen       <= '1;
         sclk      <= 1'b0;
      end else if (bus.abort && state != ST_IDLE) begin
         state <= ST_IDLE;
         cnt   <= '0;
         hp    <= '0;
         sreg  <= '0;
         sen   <= '1;
         sclk  <= cpol_lat;
      end else begin
         case (state)
            ST_IDLE: begin
               sclk <= bus.cpol;
               if (bus.start && !fifo_empty)
                  state <= ST_POP;
            end
            ST_POP: begin
               sreg      <= head[FRAME_W-1:0];
               ratio_lat <= (bus.clk_ratio == 8'd0) ?
                            8'd1 : bus.clk_ratio;
               cpol_lat  <= bus.cpol;
               sclk      <= bus.cpol;
               sen       <= head_sen;
               cnt       <= '0;
               state     <= ST_SETUP;
            end
            ST_SETUP: begin
               if (half_end) begin
                  cnt   <= '0;
                  hp    <= '0;
                  sclk  <= ~cpol_lat;
                  state <= ST_SHIFT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_SHIFT: begin
               if (half_end) begin
                  cnt <= '0;
                  if (hp == HP_LAST) begin
                     sclk  <= cpol_lat;
                     state <= ST_HOLD;
                  end else begin
                     hp   <= hp + HP_W'(1);
                     sclk <= ~sclk;
                     // even half-period ending = trailing edge next
                     if (!hp[0])
                        sreg <= {sreg[FRAME_W-2:0], 1'b0};
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_HOLD: begin
               if (half_end) begin
                  cnt   <= '0;
                  sen   <= '1;
                  state <= ST_GAP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_GAP: begin
               if (half_end) begin
                  cnt   <= '0;
                  state <= fifo_empty ? ST_IDLE : ST_POP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy       = (state != ST_IDLE);
   assign bus.done       = (state == ST_GAP) && half_end &&
                           !bus.abort;
   assign bus.fifo_full  = fifo_full;
   assign bus.fifo_empty = fifo_empty;
   assign bus.fifo_level = fifo_level;
   assign bus.overflow   = overflow;
   assign bus.SEN        = sen;
   assign bus.SCLK       = sclk;
   assign bus.SDATA      = sreg[FRAME_W-1];

endmodule

// File: tb/tb_spi_queue_cntrl.sv
// Randomized self-checking bench for spi_queue_cntrl with a
// queue-based reference model and a serial-frame monitor.
module tb_spi_queue_cntrl;
   import spi_pkg::*;

   localparam int AB    = 8;
   localparam int DB    = 16;
   localparam int DEPTH = 8;
   localparam int NCS   = 4;
   localparam int CSW   = cs_width(NCS);
   localparam int FW    = AB + DB;
   localparam int CW    = CSW + FW;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   spi_queue_cntrl_if #(
      .ADDR_BITS (AB), .DATA_BITS (DB),
      .FIFO_DEPTH (DEPTH), .NUM_CS (NCS)
   ) bus ();

   spi_queue_cntrl #(
      .ADDR_BITS (AB), .DATA_BITS (DB),
      .FIFO_DEPTH (DEPTH), .NUM_CS (NCS)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NCS-1:0] exp_sen(
      input logic [CSW-1:0] cs);
      logic [NCS-1:0] s;
      s = '1;
      if (int'(cs) < NCS)
         s[cs] = 1'b0;
      return s;
   endfunction

   // reference model + frame monitor, sampled mid-cycle
   logic [CW-1:0]  q[$];
   logic           ovf_m = 1'b0;
   int             ndone = 0;
   int             ntog  = 0;
   int             fcyc, nlead, fr;
   logic           fc, multi;
   logic           active = 1'b0;
   logic [FW-1:0]  bits;
   logic [NCS-1:0] sen_and;
   logic [CW-1:0]  cur;
   logic           p_busy = 1'b0;
   logic           p_done = 1'b0;
   logic           p_sclk = 1'b0;

   always @(negedge clock) begin
      if (!reset_n) begin
         q.delete();
         ovf_m  = 1'b0;
         active = 1'b0;
         ntog   = 0;
         p_busy = 1'b0;
         p_done = 1'b0;
         p_sclk = 1'b0;
      end else begin
         if (bus.busy && (!p_busy || p_done)) begin
            check("pop_nonempty", q.size() != 0, 1);
            cur = (q.size() != 0) ? q.pop_front() : '0;
            fr = (bus.clk_ratio == 8'd0) ?
                 1 : int'(bus.clk_ratio);
            fc      = bus.cpol;
            active  = 1'b1;
            fcyc    = 0;
            nlead   = 0;
            ntog    = 0;
            bits    = '0;
            sen_and = '1;
            multi   = 1'b0;
         end
         if (bus.cmd_wren) begin
            if (q.size() < DEPTH)
               q.push_back(bus.cmd_in);
            else
               ovf_m = 1'b1;
         end
         if (active) begin
            fcyc++;
            if (bus.SCLK != p_sclk)
               ntog++;
            if (bus.SCLK != p_sclk && bus.SCLK != fc) begin
               bits = {bits[FW-2:0], bus.SDATA};
               nlead++;
            end
            sen_and &= bus.SEN;
            if ($countones(~bus.SEN) > 1)
               multi = 1'b1;
            if (bus.done) begin
               check("frame_data", bits, cur[FW-1:0]);
               check("frame_sen", sen_and,
                     exp_sen(cur[CW-1 -: CSW]));
               check("frame_cycles", fcyc, (2*FW+3)*fr + 1);
               check("frame_edges", nlead, FW);
               check("sen_onehot", multi, 0);
               ndone++;
               active = 1'b0;
            end else if (!bus.busy) begin
               active = 1'b0;
            end
         end else if (bus.done) begin
            check("stray_done", bus.done, 0);
         end
         p_busy = bus.busy;
         p_done = bus.done;
         p_sclk = bus.SCLK;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [CW-1:0] rand_cmd();
      logic [CSW-1:0] cs;
      logic [FW-1:0]  fd;
      cs = CSW'($urandom_range(0, NCS - 1));
      fd = FW'($urandom);
      return {cs, fd};
   endfunction

   task automatic push(input logic [CW-1:0] c);
      bus.cmd_wren = 1'b1;
      bus.cmd_in   = c;
      tick();
      bus.cmd_wren = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (ndone < target && k < budget) begin
         tick();
         k++;
      end
      if (ndone < target)
         check("timeout_done", ndone, target);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (bus.busy && k < budget) begin
         tick();
         k++;
      end
      if (bus.busy)
         check("timeout_idle", bus.busy, 0);
   endtask

   task automatic wait_tog(input int n, input int budget);
      int k = 0;
      do begin
         tick();
         k++;
      end while (ntog < n && k < budget);
      if (ntog < n)
         check("timeout_sclk", ntog, n);
   endtask

   task automatic check_reset(input string t);
      check({t, "_busy"},  bus.busy, 0);
      check({t, "_done"},  bus.done, 0);
      check({t, "_sen"},   bus.SEN, {NCS{1'b1}});
      check({t, "_sclk"},  bus.SCLK, 0);
      check({t, "_sdata"}, bus.SDATA, 0);
      check({t, "_level"}, bus.fifo_level, 0);
      check({t, "_empty"}, bus.fifo_empty, 1);
      check({t, "_full"},  bus.fifo_full, 0);
      check({t, "_ovf"},   bus.overflow, 0);
   endtask

   int base;
   int n;

   initial begin
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.clk_ratio = 8'd2;
      bus.cpol      = 1'b0;
      bus.cmd_wren  = 1'b0;
      bus.cmd_in    = '0;
      repeat (3) @(posedge clock);
      #1;
      check_reset("rst");
      reset_n = 1'b1;
      tick();

      // single frame, ratio 2, cs 1
      base = ndone;
      push({2'd1, 8'hA5, 16'h1234});
      pulse_start();
      check("t1_busy", bus.busy, 1);
      wait_done(base + 1, 400);
      wait_idle(50);
      check("t1_ndone", ndone - base, 1);
      check("t1_empty", bus.fifo_empty, 1);

      // fill past full without start
      for (int i = 1; i <= 9; i++) begin
         push(rand_cmd());
         check("t2_level", bus.fifo_level, q.size());
         check("t2_full", bus.fifo_full, i >= DEPTH);
         check("t2_ovf", bus.overflow, i > DEPTH);
      end
      check("t2_level8", bus.fifo_level, DEPTH);
      check("t2_ovf_m", bus.overflow, ovf_m);
      base = ndone;
      pulse_start();
      wait_done(base + DEPTH, DEPTH * 120);
      wait_idle(100);
      check("t2_ndone", ndone - base, DEPTH);
      check("t2_busy", bus.busy, 0);
      check("t2_empty", bus.fifo_empty, 1);

      // cpol high, ratio 0 -> half-period of one cycle
      bus.cpol      = 1'b1;
      bus.clk_ratio = 8'd0;
      tick();
      tick();
      check("t3_sclk_idle", bus.SCLK, 1);
      base = ndone;
      push({2'd1, 8'hA5, 16'h1234});
      pulse_start();
      wait_done(base + 1, 200);
      wait_idle(20);
      check("t3_ndone", ndone - base, 1);
      check("t3_sclk_end", bus.SCLK, 1);

      // abort at 10th SCLK edge with 3 queued
      bus.cpol      = 1'b0;
      bus.clk_ratio = 8'd1;
      tick();
      for (int i = 0; i < 3; i++)
         push(rand_cmd());
      pulse_start();
      wait_tog(10, 200);
      base = ndone;
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("t4_sen", bus.SEN, {NCS{1'b1}});
      check("t4_sclk", bus.SCLK, 0);
      check("t4_busy", bus.busy, 0);
      check("t4_level", bus.fifo_level, 2);
      check("t4_model", bus.fifo_level, q.size());
      tick();
      check("t4_nodone", ndone - base, 0);
      pulse_start();
      wait_done(base + 2, 300);
      wait_idle(20);
      check("t4_drain", ndone - base, 2);

      // asynchronous reset mid-SHIFT
      push({2'd2, FW'($urandom)});
      push(rand_cmd());
      bus.cmd_wren = 1'b0;
      for (int i = 0; i < 9; i++)
         push(rand_cmd());
      bus.clk_ratio = 8'd3;
      pulse_start();
      wait_tog(4, 400);
      check("t5_sen_pre", bus.SEN, 4'b1011);
      check("t5_ovf_pre", bus.overflow, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset("t5");
      tick();
      reset_n = 1'b1;
      tick();
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_start_empty", bus.busy, 0);
      end
      bus.start = 1'b0;

      // ratio change mid-frame; cs 3 then cs 0
      bus.clk_ratio = 8'd3;
      base = ndone;
      push({2'd3, FW'($urandom)});
      push({2'd0, FW'($urandom)});
      pulse_start();
      wait_tog(6, 400);
      bus.clk_ratio = 8'd1;
      wait_done(base + 2, 600);
      wait_idle(20);
      check("t6_ndone", ndone - base, 2);

      // randomized traffic with concurrent writes
      for (int r = 0; r < 6; r++) begin
         bus.cpol      = 1'($urandom_range(0, 1));
         bus.clk_ratio = 8'($urandom_range(0, 3));
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++)
            push(rand_cmd());
         pulse_start();
         for (int c = 0; c < 80; c++) begin
            bus.cmd_wren = ($urandom_range(0, 7) == 0);
            bus.cmd_in   = rand_cmd();
            if ($urandom_range(0, 15) == 0)
               bus.clk_ratio = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)
               bus.cpol = 1'($urandom_range(0, 1));
            tick();
         end
         bus.cmd_wren = 1'b0;
         pulse_start();
         wait_idle(6000);
         check("rnd_level", bus.fifo_level, q.size());
         check("rnd_empty", bus.fifo_empty, 1);
         check("rnd_ovf", bus.overflow, ovf_m);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
